tx_frame_ctrl: RTL and testbench
================================

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 4, giving the bytes per frame (legal 1..4).
REQ-002 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req0 / req1  input  1 each  write request from requester 0 / 1, held until granted.
REQ-005 The block SHALL have port data0 / data1  input  8 each  byte offered by requester 0 / 1, valid while its req is high.
REQ-006 The block SHALL have port gnt0 / gnt1  output  1 each  one-cycle grant pulse; the byte is consumed in that cycle.
REQ-007 The block SHALL have port flush  input  1  pulse that forces transmission of a partial frame.
REQ-008 The block SHALL have port buf_wr  output  1  write strobe to the transmit buffer.
REQ-009 The block SHALL have port buf_addr  output  3  buffer write address.
REQ-010 The block SHALL have port buf_wdata  output  8  buffer write data.
REQ-011 The block SHALL have port buf_rd  output  1  one-cycle pulse that advances the buffer read pointer.
REQ-012 The block SHALL have port tx_start  output  1  one-cycle pulse starting the UART transmitter on the current buffer byte.
REQ-013 The block SHALL have port tx_done  input  1  one-cycle pulse from the transmitter at end of the stop bit.
REQ-014 The block SHALL have port busy  output  1  high whenever the state is not FILL.

Function
REQ-015 The FSM SHALL have exactly the states FILL, START, WAIT, NEXT and CLEAR, encoded in registers.
REQ-016 Counters: wcnt (3 bit) counts bytes written this frame; scnt (3 bit) counts bytes sent; flen (3 bit) holds the latched frame length.
REQ-017 In FILL with wcnt < FRAME_LEN, the block SHALL grant one requester per cycle, round-robin.
- When both req0 and req1 are high, the grant SHALL go to the requester not granted last; after reset, requester 0 has priority.
REQ-018 In the grant cycle, the block SHALL drive:
- gnt of the winner = 1;
- buf_wr = 1;
- buf_addr = wcnt;
- buf_wdata = the winner's data.
- wcnt SHALL increment at the next edge.
REQ-019 gnt0, gnt1 and buf_wr SHALL be low outside FILL; requests in other states SHALL stall, not be lost.
REQ-020 When wcnt reaches FRAME_LEN, the block SHALL latch flen = FRAME_LEN and enter START on the following edge.
REQ-021 Flush in FILL with wcnt > 0 and no grant that cycle: the block SHALL latch flen = wcnt and enter START.
REQ-022 Flush in FILL with wcnt = 0, or flush in any other state, SHALL be ignored.
REQ-023 If flush coincides with a grant, the grant SHALL complete first; flen SHALL then be wcnt+1 and START SHALL be entered on the next edge.
REQ-024 START SHALL assert tx_start for exactly one cycle, then go to WAIT.
REQ-025 WAIT SHALL hold all strobes low until tx_done = 1, then go to NEXT; tx_done outside WAIT SHALL be ignored.
REQ-026 NEXT SHALL pulse buf_rd for one cycle and increment scnt.
- If scnt+1 = flen, the FSM SHALL go to CLEAR; otherwise it SHALL go to START.
REQ-027 CLEAR SHALL zero wcnt and scnt, then return to FILL (one cycle).
REQ-028 Latency SHALL be as follows:
- last grant to tx_start: 2 cycles;
- tx_done to buf_rd: 1 cycle;
- tx_done to next tx_start: 2 cycles.
REQ-029 All outputs except gnt0/gnt1/buf_wr/buf_addr/buf_wdata SHALL be registered; counters SHALL never wrap past FRAME_LEN.

Reset
REQ-030 On rst_n = 0, asynchronously:
- state = FILL;
- wcnt = scnt = flen = 0;
- round-robin pointer = requester 0 priority;
- tx_start = buf_rd = busy = gnt0 = gnt1 = buf_wr = 0;
- buf_addr = 0 and buf_wdata = 0x00.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no tx_start or buf_rd SHALL follow the release of reset until a new frame is filled.

Verification
REQ-032 Single requester: req0 writes 0x11, 0x22, 0x33, 0x44 -> buf_addr 0..3, then tx_start 2 cycles after the last grant; with 4 tx_done pulses answered, 4 buf_rd pulses occur and busy falls.
REQ-033 Contention: req0 and req1 held high together -> grants alternate gnt0, gnt1, gnt0, gnt1; data order at buf_addr 0..3 is data0, data1, data0, data1.
REQ-034 Flush: 2 bytes written, then flush -> exactly 2 tx_start/buf_rd pairs, then FILL with wcnt = 0.
REQ-035 Stall: req1 held during WAIT -> no gnt1 until CLEAR completes; the first grant is in the first FILL cycle.
REQ-036 Spurious and zero-length events: tx_done in FILL and flush with wcnt = 0 -> no output change.
REQ-037 Reset during WAIT after 1 byte sent -> all outputs 0 immediately; no tx_start afterwards without new writes.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tx_frame_ctrl
//
// Collects bytes from two requesters into a small transmit buffer and, once a
// frame is complete (or a flush asks for a partial frame), walks the buffer
// byte by byte through a UART transmitter.
//
// Fill side: while the frame is not full, one requester is granted per cycle.
// When both request together, the one that was not granted last wins. The
// grant, buffer write strobe, address and data are combinational so that a
// byte is consumed in the same cycle it is granted.
//
// Send side: for each byte, START pulses tx_start and WAIT holds until the
// transmitter reports tx_done. NEXT then pulses buf_rd and either starts the
// next byte or goes to CLEAR, which rewinds the counters before filling again.
//
// Parameters
//   FRAME_LEN  bytes per full frame (1..4)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req0/req1  write requests, held until granted
//   data0/1    byte offered by each requester while its request is high
//   gnt0/gnt1  one-cycle grant; the offered byte is consumed in that cycle
//   flush      pulse forcing transmission of a partial frame
//   buf_wr     transmit buffer write strobe
//   buf_addr   transmit buffer write address
//   buf_wdata  transmit buffer write data
//   buf_rd     one-cycle pulse advancing the buffer read pointer
//   tx_start   one-cycle pulse starting the transmitter on the current byte
//   tx_done    one-cycle pulse from the transmitter at the end of the stop bit
//   busy       high whenever the controller is not filling
// -----------------------------------------------------------------------------
module tx_frame_ctrl #(
    parameter int FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       flush,
    output logic       buf_wr,
    output logic [2:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic       buf_rd,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       busy
);

    localparam logic [2:0] FLEN_C = 3'(FRAME_LEN);

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [2:0] r_wcnt;
    logic [2:0] r_scnt;
    logic [2:0] r_flen;

    // High when requester 1 holds the most recent grant, so requester 0 wins
    // the next tie. Reset sets it so requester 0 has priority first.
    logic       r_last1;

    // Held low through reset and set on the first clock afterwards; keeps the
    // combinational grant strobes quiet while rst_n is asserted.
    logic       r_rdy;

    logic       r_tx_start;
    logic       r_buf_rd;
    logic       r_busy;

    logic       w_can_grant;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_grant;
    logic [2:0] w_scnt_inc;
    logic       w_flen_load;
    logic [2:0] w_flen_val;
    logic [2:0] w_buf_addr;
    logic [7:0] w_buf_wdata;

    assign w_grant    = w_gnt0 | w_gnt1;
    assign w_scnt_inc = r_scnt + 3'd1;

    // Round-robin arbitration between the two requesters while filling
    always_comb begin
        w_can_grant = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (r_rdy && (r_state == ST_FILL) && (r_wcnt < FLEN_C)) begin
            w_can_grant = 1'b1;
        end else begin
            w_can_grant = 1'b0;
        end
        if (w_can_grant) begin
            if (req0 && req1) begin
                w_gnt0 = r_last1;
                w_gnt1 = ~r_last1;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // Buffer write address and data for the granted requester
    always_comb begin
        w_buf_addr  = 3'd0;
        w_buf_wdata = 8'h00;
        if (w_grant) begin
            w_buf_addr = r_wcnt;
        end else begin
            w_buf_addr = 3'd0;
        end
        if (w_gnt1) begin
            w_buf_wdata = data1;
        end else if (w_gnt0) begin
            w_buf_wdata = data0;
        end else begin
            w_buf_wdata = 8'h00;
        end
    end

    // Next-state logic and frame-length capture
    always_comb begin
        w_next_state = r_state;
        w_flen_load  = 1'b0;
        w_flen_val   = r_flen;
        case (r_state)
            ST_FILL: begin
                // A flush arriving with a grant lets the byte land first and
                // counts it in the frame being sent.
                if (w_grant && flush) begin
                    w_next_state = ST_START;
                    w_flen_load  = 1'b1;
                    w_flen_val   = r_wcnt + 3'd1;
                end else if (r_wcnt == FLEN_C) begin
                    w_next_state = ST_START;
                    w_flen_load  = 1'b1;
                    w_flen_val   = FLEN_C;
                end else if (flush && (r_wcnt != 3'd0)) begin
                    w_next_state = ST_START;
                    w_flen_load  = 1'b1;
                    w_flen_val   = r_wcnt;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    w_next_state = ST_NEXT;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_NEXT: begin
                // >= rather than == so a corrupted count still ends the frame
                if (w_scnt_inc >= r_flen) begin
                    w_next_state = ST_CLEAR;
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_FILL;
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame write/send counters and latched frame length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= 3'd0;
            r_scnt <= 3'd0;
            r_flen <= 3'd0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_wcnt <= 3'd0;
                r_scnt <= 3'd0;
            end else begin
                if (w_grant) begin
                    r_wcnt <= r_wcnt + 3'd1;
                end
                if (r_state == ST_NEXT) begin
                    r_scnt <= w_scnt_inc;
                end
            end
            if (w_flen_load) begin
                r_flen <= w_flen_val;
            end
        end
    end

    // Round-robin pointer and post-reset grant enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last1 <= 1'b1;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_gnt0) begin
                r_last1 <= 1'b0;
            end else if (w_gnt1) begin
                r_last1 <= 1'b1;
            end
        end
    end

    // Registered strobes decoded from the next state so each lines up with
    // the cycle the FSM spends in the matching state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start <= 1'b0;
            r_buf_rd   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_start <= (w_next_state == ST_START);
            r_buf_rd   <= (w_next_state == ST_NEXT);
            r_busy     <= (w_next_state != ST_FILL);
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign buf_wr    = w_grant;
    assign buf_addr  = w_buf_addr;
    assign buf_wdata = w_buf_wdata;
    assign tx_start  = r_tx_start;
    assign buf_rd    = r_buf_rd;
    assign busy      = r_busy;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tx_frame_ctrl (FRAME_LEN = 4).
// Each test task pushes the buffer writes it expects onto a scoreboard queue
// while driving requests; writes seen on the buffer port are popped and
// compared. A model transmitter answers every tx_start with a tx_done pulse
// three cycles later, and grant/strobe latencies are checked against cycle
// stamps taken by the bench.
// -----------------------------------------------------------------------------
module tb_tx_frame_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       req0    = 1'b0;
    logic       req1    = 1'b0;
    logic [7:0] data0   = 8'h00;
    logic [7:0] data1   = 8'h00;
    logic       flush   = 1'b0;
    logic       tx_done = 1'b0;
    logic       gnt0;
    logic       gnt1;
    logic       buf_wr;
    logic [2:0] buf_addr;
    logic [7:0] buf_wdata;
    logic       buf_rd;
    logic       tx_start;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] d0[8];
    logic [7:0] d1[8];

    tx_frame_ctrl #(.FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .flush     (flush),
        .buf_wr    (buf_wr),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .buf_rd    (buf_rd),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] outs();
        return {gnt0, gnt1, buf_wr, buf_addr, buf_wdata, tx_start, buf_rd, busy};
    endfunction

    function automatic void push_exp(input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = 3'(addr);
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Drives requests/flush, answers tx_start, scoreboards buffer writes and
    // checks latencies until exp_tx bytes have been sent and busy falls.
    task automatic run_traffic(input string name, input int n0, input int n1,
                               input bit late1, input int flush_at,
                               input int first_lat, input int exp_tx,
                               output int first_fill, output int first_g1);
        int  i0 = 0, i1 = 0, ntx = 0, nrd = 0, cd = 0;
        int  t_done = -100, last_gnt = -100;
        bit  flushed = 1'b0, new_frame = 1'b1, done = 1'b0, prev_busy = 1'b0;
        wr_t e;
        first_fill = -1;
        first_g1   = -1;
        for (int c = 0; c < 400 && !done; c++) begin
            req0  = (i0 < n0);
            data0 = d0[i0[2:0]];
            req1  = (i1 < n1) && (!late1 || ntx >= 1);
            data1 = d1[i1[2:0]];
            flush = 1'b0;
            if (flush_at >= 0 && !flushed && (i0 + i1) == flush_at) begin
                flush   = 1'b1;
                flushed = 1'b1;
            end
            tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_done = 1'b1;
                    t_done  = cyc;
                end
            end
            @(negedge clk);
            checks++;
            if (((gnt0 | gnt1) !== buf_wr) || (buf_wr && busy) || (gnt0 && gnt1)) begin
                failures++;
                $display("FAIL %s grant_strobes cyc=%0d: gnt0=%b gnt1=%b buf_wr=%b busy=%b, required single grant equal to buf_wr and busy=0 while writing",
                         name, cyc, gnt0, gnt1, buf_wr, busy);
            end
            if (buf_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_write cyc=%0d: addr=%0d data=%h, required no write",
                             name, cyc, buf_addr, buf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({buf_addr, buf_wdata} !== {e.addr, e.data}) begin
                        failures++;
                        $display("FAIL %s write cyc=%0d: addr=%0d data=%h, required addr=%0d data=%h",
                                 name, cyc, buf_addr, buf_wdata, e.addr, e.data);
                    end
                end
                last_gnt = cyc;
            end
            if (gnt0 === 1'b1) i0++;
            if (gnt1 === 1'b1) begin
                if (first_g1 < 0) first_g1 = cyc;
                i1++;
            end
            if (prev_busy && busy === 1'b0 && first_fill < 0) first_fill = cyc;
            if (tx_start === 1'b1) begin
                ntx++;
                checks++;
                if (new_frame) begin
                    if (cyc - last_gnt != first_lat) begin
                        failures++;
                        $display("FAIL %s grant_to_tx_start: %0d cycles, required %0d",
                                 name, cyc - last_gnt, first_lat);
                    end
                end else if (cyc - t_done != 2) begin
                    failures++;
                    $display("FAIL %s done_to_tx_start: %0d cycles, required 2", name, cyc - t_done);
                end
                new_frame = 1'b0;
                cd        = 3;
            end
            if (buf_rd === 1'b1) begin
                nrd++;
                checks++;
                if (cyc - t_done != 1) begin
                    failures++;
                    $display("FAIL %s done_to_buf_rd: %0d cycles, required 1", name, cyc - t_done);
                end
            end
            if (busy === 1'b0) new_frame = 1'b1;
            prev_busy = busy;
            if (nrd >= exp_tx && busy === 1'b0) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req0    = 1'b0;
        req1    = 1'b0;
        flush   = 1'b0;
        tx_done = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: frame not completed, tx_start=%0d buf_rd=%0d, required %0d each",
                     name, ntx, nrd, exp_tx);
        end
        checks++;
        if (ntx != exp_tx || nrd != exp_tx) begin
            failures++;
            $display("FAIL %s pulse_counts: tx_start=%0d buf_rd=%0d, required %0d each",
                     name, ntx, nrd, exp_tx);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_writes: %0d outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        rst_n   = 1'b0;
        req0    = 1'b1;
        req1    = 1'b1;
        data0   = 8'hFF;
        data1   = 8'hEE;
        flush   = 1'b1;
        tx_done = 1'b1;
        #1;
        checks++;
        if (outs() !== 17'd0) begin
            failures++;
            $display("FAIL reset_async outputs=%h, required 0", outs());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== 17'd0) begin
            failures++;
            $display("FAIL reset_held outputs=%h, required 0", outs());
        end
        req0    = 1'b0;
        req1    = 1'b0;
        flush   = 1'b0;
        tx_done = 1'b0;
        data0   = 8'h00;
        data1   = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== 17'd0) begin
            failures++;
            $display("FAIL reset_release_idle outputs=%h, required 0", outs());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        int ff, g1;
        for (int i = 0; i < 8; i++) begin
            d0[i] = 8'hA1 + 8'(i);
            d1[i] = 8'hB1 + 8'(i);
        end
        push_exp(0, 8'hA1);
        push_exp(1, 8'hB1);
        push_exp(2, 8'hA2);
        push_exp(3, 8'hB2);
        run_traffic("contention", 2, 2, 1'b0, -1, 2, 4, ff, g1);
    endtask

    task automatic test_single();
        int ff, g1;
        logic [7:0] b [4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            d0[i] = b[i];
            push_exp(i, b[i]);
        end
        run_traffic("single", 4, 0, 1'b0, -1, 2, 4, ff, g1);
    endtask

    task automatic test_flush();
        int ff, g1;
        d0[0] = 8'h5C;
        d0[1] = 8'h3D;
        push_exp(0, 8'h5C);
        push_exp(1, 8'h3D);
        run_traffic("flush", 2, 0, 1'b0, 2, 2, 2, ff, g1);
    endtask

    task automatic test_flush_with_grant();
        int ff, g1;
        d0[0] = 8'h71;
        d0[1] = 8'h72;
        d0[2] = 8'h73;
        push_exp(0, 8'h71);
        push_exp(1, 8'h72);
        push_exp(2, 8'h73);
        run_traffic("flush_grant", 3, 0, 1'b0, 2, 1, 3, ff, g1);
    endtask

    task automatic test_spurious();
        int ff, g1;
        for (int c = 0; c < 8; c++) begin
            tx_done = (c % 3 == 0);
            flush   = (c % 3 == 1);
            @(negedge clk);
            checks++;
            if (outs() !== 17'd0) begin
                failures++;
                $display("FAIL spurious_idle cyc=%0d outputs=%h, required 0", cyc, outs());
            end
            @(posedge clk);
            #1;
        end
        tx_done = 1'b0;
        flush   = 1'b0;
        d0[0] = 8'h5A;
        push_exp(0, 8'h5A);
        run_traffic("spurious_after", 1, 0, 1'b0, 1, 2, 1, ff, g1);
    endtask

    task automatic test_stall();
        int ff, g1;
        for (int i = 0; i < 4; i++) begin
            d0[i] = 8'h21 + 8'(i);
            d1[i] = 8'hD1 + 8'(i);
            push_exp(i, 8'h21 + 8'(i));
        end
        for (int i = 0; i < 4; i++) push_exp(i, 8'hD1 + 8'(i));
        run_traffic("stall", 4, 4, 1'b1, -1, 2, 8, ff, g1);
        checks++;
        if (g1 < 0 || g1 != ff) begin
            failures++;
            $display("FAIL stall_first_grant: gnt1 first at cyc %0d, required first FILL cyc %0d", g1, ff);
        end
    endtask

    task automatic test_reset_in_wait();
        int  g = 0, ntx = 0, cd = 0;
        bit  hit = 1'b0;
        wr_t e;
        for (int i = 0; i < 4; i++) push_exp(i, 8'hC0 + 8'(i));
        for (int c = 0; c < 100 && !hit; c++) begin
            req0    = (g < 4);
            data0   = 8'hC0 + 8'(g);
            tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end
            @(negedge clk);
            if (buf_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rst_wait_write unexpected addr=%0d data=%h", buf_addr, buf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({buf_addr, buf_wdata} !== {e.addr, e.data}) begin
                        failures++;
                        $display("FAIL rst_wait_write addr=%0d data=%h, required addr=%0d data=%h",
                                 buf_addr, buf_wdata, e.addr, e.data);
                    end
                end
                g++;
            end
            if (tx_start === 1'b1) begin
                ntx++;
                if (ntx == 1) cd = 2;
                else hit = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req0    = 1'b0;
        tx_done = 1'b0;
        exp_q.delete();
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_wait_timeout: second tx_start not seen (count %0d), required 2", ntx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 17'd0) begin
            failures++;
            $display("FAIL rst_wait_async outputs=%h, required 0", outs());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            tx_done = (c % 4 == 1);
            flush   = (c % 4 == 3);
            @(negedge clk);
            checks++;
            if ({tx_start, buf_rd, busy, buf_wr} !== 4'b0000) begin
                failures++;
                $display("FAIL rst_wait_abandon cyc=%0d tx_start=%b buf_rd=%b busy=%b buf_wr=%b, required all 0",
                         cyc, tx_start, buf_rd, busy, buf_wr);
            end
        end
        tx_done = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            d0[i] = 8'h00;
            d1[i] = 8'h00;
        end
        test_reset();
        test_contention();
        test_single();
        test_flush();
        test_flush_with_grant();
        test_spurious();
        test_stall();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
